// File: rtl/fft_peak_detect.sv
// rtl/fft_peak_detect.sv - FFT output pass-through with per-frame magnitude peak search
module fft_peak_detect #(
    parameter int FFT_LEN            = 8192,
    parameter int FFT_CHANNELS       = 2,
    parameter int FFT_AXI_DATA_WIDTH = 32,
    parameter int PEAK_CHANNEL       = 0,
    localparam int IDX_W             = (FFT_LEN > 1) ? $clog2(FFT_LEN) : 1,
    localparam int BUS_W             = FFT_CHANNELS * FFT_AXI_DATA_WIDTH
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic [BUS_W-1:0] s_axis_tdata,
    input  logic             s_axis_tvalid,
    input  logic             s_axis_tlast,
    output logic             s_axis_tready,
    output logic [BUS_W-1:0] m_axis_tdata,
    output logic             m_axis_tvalid,
    output logic             m_axis_tlast,
    input  logic             m_axis_tready,
    output logic [IDX_W-1:0] peak_index,
    output logic [31:0]      peak_mag,
    output logic             peak_len_err,
    output logic             peak_valid,
    input  logic             peak_ready
);

    localparam logic [IDX_W-1:0] LAST_BIN = IDX_W'(FFT_LEN - 1);

    typedef enum logic [1:0] {
        SCAN  = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [IDX_W-1:0] bin_cnt;
    logic             overrun;

    logic [31:0]      s1_ii;
    logic [31:0]      s1_qq;
    logic [IDX_W-1:0] s1_bin;
    logic             s1_last;
    logic             s1_err;
    logic             s1_valid;

    logic [31:0]      max_mag;
    logic [IDX_W-1:0] max_idx;
    logic             s2_last;
    logic             s2_err;

    logic [FFT_AXI_DATA_WIDTH-1:0] peak_word;
    logic signed [15:0]            samp_i;
    logic signed [15:0]            samp_q;
    logic signed [31:0]            prod_i;
    logic signed [31:0]            prod_q;
    logic [31:0]                   mag_sum;
    logic                          accept;
    logic                          frame_err;

    assign m_axis_tdata  = s_axis_tdata;
    assign m_axis_tlast  = s_axis_tlast;
    assign m_axis_tvalid = (state == SCAN) ? s_axis_tvalid : 1'b0;
    assign s_axis_tready = (state == SCAN) ? m_axis_tready : 1'b0;

    assign accept    = s_axis_tvalid && s_axis_tready && (state == SCAN);
    assign peak_word = s_axis_tdata[PEAK_CHANNEL*FFT_AXI_DATA_WIDTH +: FFT_AXI_DATA_WIDTH];
    assign samp_i    = signed'(peak_word[15:0]);
    assign samp_q    = signed'(peak_word[31:16]);
    assign prod_i    = samp_i * samp_i;
    assign prod_q    = samp_q * samp_q;
    assign mag_sum   = s1_ii + s1_qq;

    // A non-tlast beat already seen at the last bin means the frame runs past FFT_LEN beats.
    assign frame_err = (bin_cnt != LAST_BIN) || overrun;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state <= SCAN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            SCAN:    if (accept && s_axis_tlast) state_next = DRAIN;
            DRAIN:   if (s2_last) state_next = HOLD;
            HOLD:    if (peak_ready) state_next = SCAN;
            default: state_next = SCAN;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            bin_cnt <= '0;
            overrun <= 1'b0;
        end else if (accept) begin
            if (s_axis_tlast) begin
                bin_cnt <= '0;
                overrun <= 1'b0;
            end else if (bin_cnt == LAST_BIN) begin
                overrun <= 1'b1;
            end else begin
                bin_cnt <= bin_cnt + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            s1_valid <= 1'b0;
            s1_ii    <= '0;
            s1_qq    <= '0;
            s1_bin   <= '0;
            s1_last  <= 1'b0;
            s1_err   <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_ii   <= unsigned'(prod_i);
                s1_qq   <= unsigned'(prod_q);
                s1_bin  <= bin_cnt;
                s1_last <= s_axis_tlast;
                s1_err  <= s_axis_tlast && frame_err;
            end
        end
    end

    // Running max is cleared when the finished frame's result is published, ready for the next frame.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            max_mag      <= '0;
            max_idx      <= '0;
            s2_last      <= 1'b0;
            s2_err       <= 1'b0;
            peak_index   <= '0;
            peak_mag     <= '0;
            peak_len_err <= 1'b0;
            peak_valid   <= 1'b0;
        end else begin
            s2_last <= s1_valid && s1_last;
            if (s1_valid) begin
                if (mag_sum > max_mag) begin
                    max_mag <= mag_sum;
                    max_idx <= s1_bin;
                end
                if (s1_last) s2_err <= s1_err;
            end
            if (s2_last) begin
                peak_index   <= max_idx;
                peak_mag     <= max_mag;
                peak_len_err <= s2_err;
                peak_valid   <= 1'b1;
                max_mag      <= '0;
                max_idx      <= '0;
            end else if (peak_valid && peak_ready) begin
                peak_valid <= 1'b0;
            end
        end
    end

endmodule
